// File: rtl/csr_trap_seq_pkg.sv
// Shared types and constants for the CSR write-port trap sequencer.
// The vectored-interrupt option is selected with CSR_TRAP_VECTORED_EN (see csr_trap_seq.sv).
package csr_trap_seq_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WR_EPC     = 3'd1,
    WR_CAUSE   = 3'd2,
    WR_TVAL    = 3'd3,
    WR_STAT    = 3'd4,
    REDIR      = 3'd5,
    MRET_REDIR = 3'd6
  } trap_state_t;

  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_MEI = 4'd11;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;

endpackage

// File: rtl/csr_trap_seq_cause_enc.sv
// Pending-interrupt qualifier and priority encoder: meip > msip > mtip,
// gated by the global mstatus.MIE enable.
module trap_cause_enc
  import csr_trap_seq_pkg::*;
(
  input  logic [2:0] irq_pend,
  input  logic [2:0] irq_en,
  input  logic       gie,
  output logic       irq,
  output logic [3:0] irq_code
);

  logic [2:0] act;

  // Bit order is {meip, mtip, msip}; msip outranks mtip.
  always_comb begin
    act      = irq_pend & irq_en;
    irq      = (|act) & gie;
    irq_code = 4'd0;
    if (act[2]) begin
      irq_code = IRQ_MEI;
    end else if (act[0]) begin
      irq_code = IRQ_MSI;
    end else if (act[1]) begin
      irq_code = IRQ_MTI;
    end else begin
      irq_code = 4'd0;
    end
  end

endmodule

// File: rtl/csr_trap_seq.sv
// Arbiter/sequencer for the single CSR write port: CSR writeback, trap entry and mret.
// Optional build macro CSR_TRAP_VECTORED_EN enables vectored interrupt targets.
module csr_trap_seq
  import csr_trap_seq_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            exc_valid,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [3:0]      exc_code,
  input  logic [XLEN-1:0] exc_tval,
  input  logic [2:0]      irq_pend,
  input  logic [2:0]      irq_en,
  input  logic [XLEN-1:0] commit_pc,
  input  logic            mret_valid,
  input  logic            wb_valid,
  input  logic [11:0]     wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            wb_ready,
  input  logic [XLEN-1:0] csr_mstatus,
  input  logic [XLEN-1:0] csr_mtvec,
  input  logic [XLEN-1:0] csr_mepc,
  output logic            csr_we,
  output logic [11:0]     csr_wa,
  output logic [XLEN-1:0] csr_wd,
  output logic            csr_is_mret,
  output logic            trap_ready,
  output logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  trap_state_t     state_q, state_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic [XLEN-1:0] mstatus_q, mstatus_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic            irq;
  logic [3:0]      irq_code;
  logic [XLEN-1:0] mstatus_new;
  logic [XLEN-1:0] target;
`ifdef CSR_TRAP_VECTORED_EN
  logic            vec_q, vec_d;
`endif

  trap_cause_enc u_cause_enc (
    .irq_pend (irq_pend),
    .irq_en   (irq_en),
    .gie      (csr_mstatus[MSTATUS_MIE]),
    .irq      (irq),
    .irq_code (irq_code)
  );

  // Trap-entry mstatus image and redirect target, both built from the snapshot.
  always_comb begin
    mstatus_new = mstatus_q;
    mstatus_new[MSTATUS_MPIE] = mstatus_q[MSTATUS_MIE];
    mstatus_new[MSTATUS_MIE]  = 1'b0;
    mstatus_new[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
`ifdef CSR_TRAP_VECTORED_EN
    if (vec_q) begin
      target = mtvec_q + {{(XLEN-6){1'b0}}, cause_q[3:0], 2'b00};
    end else begin
      target = mtvec_q;
    end
`else
    target = mtvec_q;
`endif
  end

  // Next-state, snapshot capture and port outputs.
  always_comb begin
    state_d   = state_q;
    epc_d     = epc_q;
    cause_d   = cause_q;
    tval_d    = tval_q;
    mstatus_d = mstatus_q;
    mtvec_d   = mtvec_q;
`ifdef CSR_TRAP_VECTORED_EN
    vec_d     = vec_q;
`endif
    csr_we         = 1'b0;
    csr_wa         = 12'h000;
    csr_wd         = {XLEN{1'b0}};
    csr_is_mret    = 1'b0;
    trap_ready     = 1'b0;
    wb_ready       = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = {XLEN{1'b0}};

    case (state_q)
      IDLE: begin
        trap_ready = 1'b1;
        if (exc_valid || irq) begin
          flush     = 1'b1;
          state_d   = WR_EPC;
          epc_d     = (exc_valid ? exc_pc : commit_pc) & ALIGN_MASK;
          cause_d   = exc_valid ? {{(XLEN-4){1'b0}}, exc_code}
                                : {1'b1, {(XLEN-5){1'b0}}, irq_code};
          tval_d    = exc_valid ? exc_tval : {XLEN{1'b0}};
          mstatus_d = csr_mstatus;
          mtvec_d   = csr_mtvec & ALIGN_MASK;
`ifdef CSR_TRAP_VECTORED_EN
          vec_d     = !exc_valid && (csr_mtvec[1:0] == 2'b01);
`endif
        end else if (mret_valid) begin
          csr_is_mret = 1'b1;
          flush       = 1'b1;
          state_d     = MRET_REDIR;
        end else begin
          wb_ready = 1'b1;
          if (wb_valid) begin
            csr_we = 1'b1;
            csr_wa = wb_addr;
            csr_wd = wb_data;
          end else begin
            csr_we = 1'b0;
          end
        end
      end
      WR_EPC: begin
        flush   = 1'b1;
        csr_we  = 1'b1;
        csr_wa  = CSR_MEPC;
        csr_wd  = epc_q;
        state_d = WR_CAUSE;
      end
      WR_CAUSE: begin
        flush   = 1'b1;
        csr_we  = 1'b1;
        csr_wa  = CSR_MCAUSE;
        csr_wd  = cause_q;
        state_d = WR_TVAL;
      end
      WR_TVAL: begin
        flush   = 1'b1;
        csr_we  = 1'b1;
        csr_wa  = CSR_MTVAL;
        csr_wd  = tval_q;
        state_d = WR_STAT;
      end
      WR_STAT: begin
        flush   = 1'b1;
        csr_we  = 1'b1;
        csr_wa  = CSR_MSTATUS;
        csr_wd  = mstatus_new;
        state_d = REDIR;
      end
      REDIR: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = target;
        state_d        = IDLE;
      end
      MRET_REDIR: begin
        // csr_mepc already reflects the CSR file's mret update by now.
        redirect_valid = 1'b1;
        redirect_pc    = csr_mepc;
        state_d        = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A reset cycle must not leak a half-finished trap onto the port.
    if (reset) begin
      csr_we         = 1'b0;
      csr_wa         = 12'h000;
      csr_wd         = {XLEN{1'b0}};
      csr_is_mret    = 1'b0;
      flush          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = {XLEN{1'b0}};
      trap_ready     = 1'b1;
      wb_ready       = 1'b1;
    end else begin
      trap_ready = trap_ready;
    end
  end

  // State and trap snapshot registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      epc_q     <= {XLEN{1'b0}};
      cause_q   <= {XLEN{1'b0}};
      tval_q    <= {XLEN{1'b0}};
      mstatus_q <= {XLEN{1'b0}};
      mtvec_q   <= {XLEN{1'b0}};
`ifdef CSR_TRAP_VECTORED_EN
      vec_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      epc_q     <= epc_d;
      cause_q   <= cause_d;
      tval_q    <= tval_d;
      mstatus_q <= mstatus_d;
      mtvec_q   <= mtvec_d;
`ifdef CSR_TRAP_VECTORED_EN
      vec_q     <= vec_d;
`endif
    end
  end

endmodule

// File: tb/tb_csr_trap_seq.sv
// Scoreboard bench for csr_trap_seq: expected port events are queued by the
// stimulus and checked in order by an independent negedge monitor.
module tb_csr_trap_seq;
  import csr_trap_seq_pkg::*;

  localparam int XLEN = 64;
  localparam int EV_WR = 0, EV_MRET = 1, EV_REDIR = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            exc_valid;
  logic [XLEN-1:0] exc_pc;
  logic [3:0]      exc_code;
  logic [XLEN-1:0] exc_tval;
  logic [2:0]      irq_pend, irq_en;
  logic [XLEN-1:0] commit_pc;
  logic            mret_valid;
  logic            wb_valid;
  logic [11:0]     wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            wb_ready;
  logic [XLEN-1:0] csr_mstatus, csr_mtvec, csr_mepc;
  logic            csr_we;
  logic [11:0]     csr_wa;
  logic [XLEN-1:0] csr_wd;
  logic            csr_is_mret, trap_ready, flush, redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  typedef struct {
    int          kind;
    logic [11:0] addr;
    logic [63:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  csr_trap_seq #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .exc_valid(exc_valid), .exc_pc(exc_pc), .exc_code(exc_code), .exc_tval(exc_tval),
    .irq_pend(irq_pend), .irq_en(irq_en), .commit_pc(commit_pc),
    .mret_valid(mret_valid),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
    .csr_mstatus(csr_mstatus), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
    .csr_we(csr_we), .csr_wa(csr_wa), .csr_wd(csr_wd), .csr_is_mret(csr_is_mret),
    .trap_ready(trap_ready), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [11:0] a, input logic [63:0] d);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_trap(input logic [63:0] epc, input logic [63:0] cause,
                           input logic [63:0] tval, input logic [63:0] mst,
                           input logic [63:0] tgt);
    push(EV_WR, CSR_MEPC, epc);
    push(EV_WR, CSR_MCAUSE, cause);
    push(EV_WR, CSR_MTVAL, tval);
    push(EV_WR, CSR_MSTATUS, mst);
    push(EV_REDIR, 12'h000, tgt);
  endtask

  task automatic see(input string name, input int k, input logic [11:0] a, input logic [63:0] d);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: got unexpected event addr %h data %h, expected none", name, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.addr !== a || e.data !== d) begin
        n_bad++;
        $display("FAIL %s: got kind %0d addr %h data %h expected kind %0d addr %h data %h",
                 name, k, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask

  // Monitor: every port event must match the head of the expectation queue.
  always @(negedge clk) begin
    if (csr_we === 1'b1)         see("csr_write", EV_WR, csr_wa, csr_wd);
    if (csr_is_mret === 1'b1)    see("mret_strobe", EV_MRET, 12'h000, 64'h0);
    if (redirect_valid === 1'b1) see("redirect", EV_REDIR, 12'h000, redirect_pc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; exc_valid = 1'b0; exc_pc = 64'h0; exc_code = 4'h0; exc_tval = 64'h0;
    irq_pend = 3'b000; irq_en = 3'b000; commit_pc = 64'h0; mret_valid = 1'b0;
    wb_valid = 1'b0; wb_addr = 12'h000; wb_data = 64'h0;
    csr_mstatus = 64'h0; csr_mtvec = 64'h0; csr_mepc = 64'h0;
    tick(); tick();
    chk("reset_trap_ready", trap_ready, 1'b1);
    chk("reset_wb_ready", wb_ready, 1'b1);
    chk("reset_flush", flush, 1'b0);
    chk("reset_redirect", redirect_valid, 1'b0);
    chk("reset_we", csr_we, 1'b0);
    reset = 1'b0;
    tick();

    // wb pass-through
    push(EV_WR, CSR_MSCRATCH, 64'hDEAD);
    wb_valid = 1'b1; wb_addr = CSR_MSCRATCH; wb_data = 64'hDEAD;
    #1 chk("wb_ready_idle", wb_ready, 1'b1);
    tick(); wb_valid = 1'b0;

    // exception with a competing, held wb write; mtvec changes after accept
    push_trap(64'h8000_0104, 64'h2, 64'h13, 64'h1880, 64'h8000_0200);
    push(EV_WR, CSR_MSCRATCH, 64'hBEEF);
    exc_valid = 1'b1; exc_pc = 64'h8000_0104; exc_code = 4'd2; exc_tval = 64'h13;
    csr_mstatus = 64'h8; csr_mtvec = 64'h8000_0200;
    wb_valid = 1'b1; wb_addr = CSR_MSCRATCH; wb_data = 64'hBEEF;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("wb_ready_in_trap", wb_ready, 1'b0);
      chk("flush_in_trap", flush, 1'b1);
      chk("trap_ready_in_trap", trap_ready, (i == 0) ? 1'b1 : 1'b0);
      tick();
      exc_valid = 1'b0; csr_mtvec = 64'hFFFF_0000;
    end
    #1 chk("wb_ready_after_trap", wb_ready, 1'b1);
    chk("flush_after_trap", flush, 1'b0);
    tick(); wb_valid = 1'b0;

    // meip interrupt (highest priority), mstatus.SIE preserved
`ifdef CSR_TRAP_VECTORED_EN
    push_trap(64'h8000_0010, 64'h8000_0000_0000_000B, 64'h0, 64'h1882, 64'h8000_022C);
`else
    push_trap(64'h8000_0010, 64'h8000_0000_0000_000B, 64'h0, 64'h1882, 64'h8000_0200);
`endif
    irq_pend = 3'b111; irq_en = 3'b111; csr_mstatus = 64'hA;
    commit_pc = 64'h8000_0010; csr_mtvec = 64'h8000_0201;
    tick(); irq_pend = 3'b000;
    repeat (5) tick();

    // msip beats mtip; misaligned commit_pc gets aligned
`ifdef CSR_TRAP_VECTORED_EN
    push_trap(64'h8000_0020, 64'h8000_0000_0000_0003, 64'h0, 64'h1880, 64'h8000_030C);
`else
    push_trap(64'h8000_0020, 64'h8000_0000_0000_0003, 64'h0, 64'h1880, 64'h8000_0300);
`endif
    irq_pend = 3'b011; irq_en = 3'b111; csr_mstatus = 64'h8;
    commit_pc = 64'h8000_0022; csr_mtvec = 64'h8000_0301;
    tick(); irq_pend = 3'b000;
    repeat (5) tick();

    // mtip alone, direct mode; MPIE already set
    push_trap(64'h8000_0044, 64'h8000_0000_0000_0007, 64'h0, 64'h1880, 64'h8000_0400);
    irq_pend = 3'b010; irq_en = 3'b110; csr_mstatus = 64'h88;
    commit_pc = 64'h8000_0044; csr_mtvec = 64'h8000_0400;
    tick(); irq_pend = 3'b000;
    repeat (5) tick();

    // pending interrupt with MIE=0 is not taken; wb proceeds
    push(EV_WR, CSR_MSCRATCH, 64'h1234);
    irq_pend = 3'b111; irq_en = 3'b111; csr_mstatus = 64'h0;
    wb_valid = 1'b1; wb_data = 64'h1234;
    #1 chk("wb_ready_gie_off", wb_ready, 1'b1);
    tick(); wb_valid = 1'b0; irq_pend = 3'b000;

    // mret beats wb
    push(EV_MRET, 12'h000, 64'h0);
    push(EV_REDIR, 12'h000, 64'h8000_0104);
    mret_valid = 1'b1; wb_valid = 1'b1; wb_data = 64'h5555; csr_mepc = 64'h8000_0104;
    #1 chk("wb_ready_mret", wb_ready, 1'b0);
    chk("flush_mret", flush, 1'b1);
    tick(); mret_valid = 1'b0; wb_valid = 1'b0;
    #1 chk("trap_ready_mret_redir", trap_ready, 1'b0);
    tick();

    // exception and mret together: exception only
    push_trap(64'h1000, 64'h5, 64'h0, 64'h1800, 64'h2000);
    exc_valid = 1'b1; mret_valid = 1'b1; exc_pc = 64'h1000; exc_code = 4'd5;
    exc_tval = 64'h0; csr_mstatus = 64'h0; csr_mtvec = 64'h2000;
    tick(); exc_valid = 1'b0; mret_valid = 1'b0;
    repeat (5) tick();

    // reset while in WR_CAUSE
    push(EV_WR, CSR_MEPC, 64'h3000);
    exc_valid = 1'b1; exc_pc = 64'h3000; exc_code = 4'd7; exc_tval = 64'hAA; csr_mtvec = 64'h4000;
    tick(); exc_valid = 1'b0;
    tick(); reset = 1'b1;
    #1 chk("we_in_reset", csr_we, 1'b0);
    tick(); reset = 1'b0;
    #1 chk("trap_ready_after_reset", trap_ready, 1'b1);
    chk("flush_after_reset", flush, 1'b0);
    repeat (5) begin
      tick();
      chk("no_redirect_after_reset", redirect_valid, 1'b0);
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d events outstanding expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
